// File: rtl/fwd_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
//   Shared types for the back-end pipeline controller (fwd_pipe_ctrl).
//   - fwd_sel_t : operand source select driven to the EX operand muxes.
//   - idex_t / exmem_t / memwb_t : contents of the three stage registers.
//   The stage records are sized by the FWD_* widths below. fwd_pipe_ctrl
//   refuses to elaborate with parameters that disagree with them.
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int FWD_DATA_W  = 64;
    localparam int FWD_REG_W   = 5;
    localparam int FWD_NUM_SRC = 2;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef logic [FWD_REG_W-1:0]  reg_idx_t;
    typedef logic [FWD_DATA_W-1:0] data_t;

    typedef struct packed {
        logic                             valid;
        reg_idx_t                         rd;
        reg_idx_t [FWD_NUM_SRC-1:0]       src;
        logic                             regwrite;
        logic                             memread;
    } idex_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
        logic     memread;
        data_t    result;
    } exmem_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
        data_t    data;
    } memwb_t;

endpackage

// File: rtl/fwd_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_pipe_ctrl_if
//   Bundles every non-clock/reset signal of fwd_pipe_ctrl.
//   master : decode / datapath side (drives id_*, flush, ex_result, mem_rdata)
//   slave  : the controller (drives stall, fwd_sel, fwd_data, wb_*)
//   id_src   : source i at [i*REG_W +: REG_W]
//   fwd_sel  : source i at [i*2 +: 2]
//   fwd_data : source i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
interface fwd_pipe_ctrl_if #(
    parameter int DATA_W  = 64,
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2
);
    logic                        id_valid;
    logic [REG_W-1:0]            id_rd;
    logic [NUM_SRC*REG_W-1:0]    id_src;
    logic                        id_regwrite;
    logic                        id_memread;
    logic                        flush;
    logic [DATA_W-1:0]           ex_result;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        stall;
    logic [NUM_SRC*2-1:0]        fwd_sel;
    logic [NUM_SRC*DATA_W-1:0]   fwd_data;
    logic                        wb_en;
    logic [REG_W-1:0]            wb_rd;
    logic [DATA_W-1:0]           wb_data;

    modport master (
        output id_valid, id_rd, id_src, id_regwrite, id_memread,
        output flush, ex_result, mem_rdata,
        input  stall, fwd_sel, fwd_data, wb_en, wb_rd, wb_data
    );

    modport slave (
        input  id_valid, id_rd, id_src, id_regwrite, id_memread,
        input  flush, ex_result, mem_rdata,
        output stall, fwd_sel, fwd_data, wb_en, wb_rd, wb_data
    );
endinterface

// File: rtl/fwd_pipe_ctrl_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Width-parametrised pipeline register.
//   clk    : rising-edge clock
//   reset  : synchronous active-high, clears q
//   hold   : keep current contents
//   bubble : load all-zero (valid=0) record
//   d / q  : next / current record
//   Priority: reset > bubble > hold > load.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fwd_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_pipe_ctrl
//   Control/tag state of the ID/EX, EX/MEM and MEM/WB stage registers of the
//   5-stage LEGv8 pipeline, with load-use stall, branch flush, operand
//   forwarding selects/data and the register-file writeback port.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fwd_pipe_ctrl_if.slave
//           in : id_valid, id_rd, id_src, id_regwrite, id_memread, flush,
//                ex_result, mem_rdata
//           out: stall, fwd_sel, fwd_data, wb_en, wb_rd, wb_data
// -----------------------------------------------------------------------------
module fwd_pipe_ctrl
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = 31
) (
    input  logic           clk,
    input  logic           reset,
    fwd_pipe_ctrl_if.slave bus
);
    // Stage records have a fixed layout taken from the package.
    if (DATA_W != FWD_DATA_W || REG_W != FWD_REG_W || NUM_SRC != FWD_NUM_SRC) begin : g_width_check
        $error("fwd_pipe_ctrl: parameters must match fwd_pkg stage widths");
    end

    localparam reg_idx_t XZR = reg_idx_t'(ZERO_REG);

    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    logic [IDEX_W-1:0]  idex_qv;
    logic [EXMEM_W-1:0] exmem_qv;
    logic [MEMWB_W-1:0] memwb_qv;

    logic stall_c;

    // An older stage can supply source s. EX/MEM excludes loads: their data
    // only exists after MEM, and the stall guarantees they are taken from MEM/WB.
    function automatic logic exmem_hit(input exmem_t r, input reg_idx_t s);
        return (s != XZR) && r.valid && r.regwrite && !r.memread && (r.rd == s);
    endfunction

    function automatic logic memwb_hit(input memwb_t r, input reg_idx_t s);
        return (s != XZR) && r.valid && r.regwrite && (r.rd == s);
    endfunction

    // ---- decode -> ID/EX ----
    always_comb begin
        idex_d          = '0;
        idex_d.valid    = bus.id_valid;
        idex_d.rd       = bus.id_rd;
        idex_d.regwrite = bus.id_regwrite;
        idex_d.memread  = bus.id_memread;
        for (int i = 0; i < NUM_SRC; i++) begin
            idex_d.src[i] = bus.id_src[i*REG_W +: REG_W];
        end
    end

    // Load in EX whose destination the decoding instruction reads.
    always_comb begin
        logic src_hit;
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idex_d.src[i] == idex_q.rd) begin
                src_hit = 1'b1;
            end
        end
        stall_c = idex_q.valid & idex_q.memread & idex_q.regwrite &
                  (idex_q.rd != XZR) & bus.id_valid & src_hit;
    end

    // A flush overrides the stall: both bubble ID/EX, but only the flush
    // also kills the instruction moving into EX/MEM.
    pipe_stage_reg #(.W(IDEX_W)) u_idex (
        .clk    (clk),
        .reset  (reset),
        .hold   (1'b0),
        .bubble (bus.flush | stall_c),
        .d      (idex_d),
        .q      (idex_qv)
    );
    assign idex_q = idex_qv;

    // ---- ID/EX -> EX/MEM ----
    always_comb begin
        exmem_d          = '0;
        exmem_d.valid    = idex_q.valid;
        exmem_d.rd       = idex_q.rd;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.result   = bus.ex_result;
    end

    pipe_stage_reg #(.W(EXMEM_W)) u_exmem (
        .clk    (clk),
        .reset  (reset),
        .hold   (1'b0),
        .bubble (bus.flush),
        .d      (exmem_d),
        .q      (exmem_qv)
    );
    assign exmem_q = exmem_qv;

    // ---- EX/MEM -> MEM/WB ----
    // The branch being flushed sits in MEM and still completes.
    always_comb begin
        memwb_d          = '0;
        memwb_d.valid    = exmem_q.valid;
        memwb_d.rd       = exmem_q.rd;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.data     = exmem_q.memread ? bus.mem_rdata : exmem_q.result;
    end

    pipe_stage_reg #(.W(MEMWB_W)) u_memwb (
        .clk    (clk),
        .reset  (reset),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (memwb_d),
        .q      (memwb_qv)
    );
    assign memwb_q = memwb_qv;

    // ---- EX operand forwarding ----
    always_comb begin
        bus.fwd_sel  = '0;
        bus.fwd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exmem_hit(exmem_q, idex_q.src[i])) begin
                bus.fwd_sel[i*2 +: 2]           = FWD_EXMEM;
                bus.fwd_data[i*DATA_W +: DATA_W] = exmem_q.result;
            end else if (memwb_hit(memwb_q, idex_q.src[i])) begin
                bus.fwd_sel[i*2 +: 2]           = FWD_MEMWB;
                bus.fwd_data[i*DATA_W +: DATA_W] = memwb_q.data;
            end
        end
    end

    // ---- writeback ----
    assign bus.stall   = stall_c;
    assign bus.wb_en   = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != XZR);
    assign bus.wb_rd   = memwb_q.rd;
    assign bus.wb_data = memwb_q.data;

endmodule
